// File: rtl/c3aibadapt_txdp_wa_lock_ctrl_if.sv
// Signal bundle between the AIB TX data input / status registers and the word-align lock controller.
// DWIDTH is the TX word width; the marker sits at bit 39 or bit 19, so DWIDTH must be at least 40.
interface c3aibadapt_txdp_wa_lock_ctrl_if #(
  parameter int DWIDTH = 40
);
  logic              r_wa_en;
  logic              r_err_clr;
  logic              mark_bit_location;
  logic [DWIDTH-1:0] aib_hssi_tx_data_in;
  logic              wa_lock;
  logic              fifo_wr_en;
  logic              wa_loss_pulse;
  logic              wa_err_sticky;
  logic [7:0]        err_cnt;
  logic [19:0]       wa_ctrl_testbus;

  // Master drives the TX word and control bits; slave is the lock controller.
  modport master (
    output r_wa_en, r_err_clr, mark_bit_location, aib_hssi_tx_data_in,
    input  wa_lock, fifo_wr_en, wa_loss_pulse, wa_err_sticky, err_cnt, wa_ctrl_testbus
  );

  modport slave (
    input  r_wa_en, r_err_clr, mark_bit_location, aib_hssi_tx_data_in,
    output wa_lock, fifo_wr_en, wa_loss_pulse, wa_err_sticky, err_cnt, wa_ctrl_testbus
  );
endinterface

// File: rtl/c3aibadapt_txdp_wa_lock_ctrl.sv
// TX word-align lock controller: HUNT/VERIFY/LOCKED on the alternating word marker, gates FIFO writes.
// Optional macro C3AIBADAPT_WA_RELOCK_EN: loss of alignment returns to HUNT instead of keeping a sticky lock.
module c3aibadapt_txdp_wa_lock_ctrl #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input logic                              wr_clk,
  input logic                              wr_srst,
  c3aibadapt_txdp_wa_lock_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BYPASS = 3'd1,
    ST_HUNT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  state_t     r_state;
  logic       r_mk_q;
  logic       r_mk_prev;
  logic [3:0] r_vcnt;
  logic [3:0] r_ecnt;
  logic [7:0] r_err_cnt;
  logic       r_err_sticky;

  logic w_mk_sel;
  logic w_match;
  logic w_err_inc;
  logic w_loss_evt;
  logic w_unused;

  assign w_mk_sel = bus.mark_bit_location ? bus.aib_hssi_tx_data_in[19]
                                          : bus.aib_hssi_tx_data_in[39];
  assign w_unused = ^bus.aib_hssi_tx_data_in;

  // A good word boundary shows up as a toggle of the marker between consecutive words.
  assign w_match    = r_mk_q ^ r_mk_prev;
  assign w_err_inc  = (r_state == ST_LOCKED) && bus.r_wa_en && !w_match;
  assign w_loss_evt = w_err_inc && ((r_ecnt + 4'd1) == UNLOCK_C);

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge wr_clk) begin
    if (wr_srst) begin
      r_state      <= ST_IDLE;
      r_mk_q       <= 1'b0;
      r_mk_prev    <= 1'b0;
      r_vcnt       <= 4'd0;
      r_ecnt       <= 4'd0;
      r_err_cnt    <= 8'd0;
      r_err_sticky <= 1'b0;
    end else begin
      r_mk_q    <= w_mk_sel;
      r_mk_prev <= r_mk_q;

      case (r_state)
        ST_IDLE: r_state <= bus.r_wa_en ? ST_HUNT : ST_BYPASS;
        ST_BYPASS: begin
          if (bus.r_wa_en) begin
            r_state <= ST_HUNT;
            r_vcnt  <= 4'd0;
          end
        end
        ST_HUNT: begin
          if (!bus.r_wa_en) begin
            r_state <= ST_BYPASS;
          end else if (w_match) begin
            r_state <= ST_VERIFY;
            r_vcnt  <= 4'd1;
          end
        end
        ST_VERIFY: begin
          if (!bus.r_wa_en) begin
            r_state <= ST_BYPASS;
          end else if (w_match) begin
            r_vcnt <= r_vcnt + 4'd1;
            if ((r_vcnt + 4'd1) == LOCK_C) begin
              r_state <= ST_LOCKED;
              r_ecnt  <= 4'd0;
            end
          end else begin
            r_state <= ST_HUNT;
            r_vcnt  <= 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!bus.r_wa_en) begin
            r_state <= ST_BYPASS;
          end else if (w_match) begin
            r_ecnt <= 4'd0;
          end else if (w_loss_evt) begin
            r_ecnt <= 4'd0;
`ifdef C3AIBADAPT_WA_RELOCK_EN
            r_state <= ST_HUNT;
            r_vcnt  <= 4'd0;
`endif
          end else begin
            r_ecnt <= r_ecnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Clear has priority over a same-cycle error.
      if (bus.r_err_clr) begin
        r_err_cnt <= 8'd0;
      end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (bus.r_err_clr) begin
        r_err_sticky <= 1'b0;
      end else if (w_loss_evt) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign bus.wa_lock         = (r_state == ST_LOCKED) || (r_state == ST_BYPASS);
  assign bus.fifo_wr_en      = (r_state == ST_LOCKED) || (r_state == ST_BYPASS);
  assign bus.wa_err_sticky   = r_err_sticky;
  assign bus.err_cnt         = r_err_cnt;
  assign bus.wa_ctrl_testbus = {7'd0, r_state, r_vcnt, r_ecnt, r_mk_q, r_mk_prev};

`ifdef C3AIBADAPT_WA_RELOCK_EN
  // High during the cycle whose edge leaves LOCKED; lock drops after that edge.
  assign bus.wa_loss_pulse = w_loss_evt && !wr_srst;
`else
  assign bus.wa_loss_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_c3aibadapt_txdp_wa_lock_ctrl.sv
// Randomized self-checking bench for the TX word-align lock controller against a behavioural model.
module tb_c3aibadapt_txdp_wa_lock_ctrl;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;

  logic wr_clk = 1'b0;
  logic wr_srst;
  always #5 wr_clk = ~wr_clk;

  c3aibadapt_txdp_wa_lock_ctrl_if #(.DWIDTH(40)) bus ();

  c3aibadapt_txdp_wa_lock_ctrl #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_dut (
    .wr_clk (wr_clk),
    .wr_srst(wr_srst),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses_seen = 0;

  // Model: mode 0 idle, 1 bypass, 2 hunting, 3 verifying, 4 locked (testbus encoding).
  int m_mode;
  int m_run;
  int m_bad;
  int m_errs;
  bit m_sticky;
  bit hist [2];  // hist[1] newest sampled marker, hist[0] the one before
  bit last_mk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_locked();
    return (m_mode == 1) || (m_mode == 4);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_bad = 0; m_errs = 0; m_sticky = 0;
    hist[0] = 0; hist[1] = 0;
  endtask

  task automatic tick();
    bit rst, en, clr, mk, match, miss_locked, loss;
    #1;
    rst   = wr_srst;
    en    = bus.r_wa_en;
    clr   = bus.r_err_clr;
    mk    = bus.mark_bit_location ? bus.aib_hssi_tx_data_in[19] : bus.aib_hssi_tx_data_in[39];
    match = (hist[1] != hist[0]);
    miss_locked = !rst && en && (m_mode == 4) && !match;
    loss  = miss_locked && (m_bad + 1 == UNLOCK_CNT);
    if (bus.wa_loss_pulse) pulses_seen++;
`ifdef C3AIBADAPT_WA_RELOCK_EN
    check("loss_pulse", {31'd0, bus.wa_loss_pulse}, {31'd0, loss});
`else
    check("loss_pulse", {31'd0, bus.wa_loss_pulse}, 32'd0);
`endif
    @(posedge wr_clk);
    if (rst) begin
      model_reset();
    end else begin
      if (miss_locked) m_errs = (m_errs >= 255) ? 255 : m_errs + 1;
      if (loss) m_sticky = 1;
      if (clr) begin m_errs = 0; m_sticky = 0; end
      if (m_mode == 0) m_mode = en ? 2 : 1;
      else if (!en) m_mode = 1;
      else if (m_mode == 1) begin m_mode = 2; m_run = 0; end
      else if (m_mode == 2) begin
        if (match) begin m_mode = 3; m_run = 1; end
      end else if (m_mode == 3) begin
        if (match) begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_mode = 4; m_bad = 0; end
        end else begin
          m_mode = 2; m_run = 0;
        end
      end else begin
        if (match) m_bad = 0;
        else if (loss) begin
          m_bad = 0;
`ifdef C3AIBADAPT_WA_RELOCK_EN
          m_mode = 2; m_run = 0;
`endif
        end else m_bad++;
      end
      hist[0] = hist[1];
      hist[1] = mk;
    end
    @(negedge wr_clk);
    check("wa_lock", {31'd0, bus.wa_lock}, {31'd0, m_locked()});
    check("fifo_wr_en", {31'd0, bus.fifo_wr_en}, {31'd0, m_locked()});
    check("err_cnt", {24'd0, bus.err_cnt}, m_errs);
    check("err_sticky", {31'd0, bus.wa_err_sticky}, {31'd0, m_sticky});
    check("tb_zero", {25'd0, bus.wa_ctrl_testbus[19:13]}, 32'd0);
    check("tb_state", {29'd0, bus.wa_ctrl_testbus[12:10]}, m_mode);
    check("tb_mk", {30'd0, bus.wa_ctrl_testbus[1:0]}, {30'd0, hist[1], hist[0]});
    if (m_mode == 2 || m_mode == 3)
      check("tb_vcnt", {28'd0, bus.wa_ctrl_testbus[9:6]}, (m_mode == 2) ? 0 : m_run);
    if (m_mode == 4)
      check("tb_ecnt", {28'd0, bus.wa_ctrl_testbus[5:2]}, m_bad);
  endtask

  task automatic send(input bit mk);
    logic [63:0] r;
    r = {$urandom, $urandom};
    bus.aib_hssi_tx_data_in = r[39:0];
    if (bus.mark_bit_location) bus.aib_hssi_tx_data_in[19] = mk;
    else                       bus.aib_hssi_tx_data_in[39] = mk;
    last_mk = mk;
    tick();
  endtask

  task automatic good();
    send(~last_mk);
  endtask

  task automatic miss();
    send(last_mk);
  endtask

  task automatic do_reset();
    wr_srst = 1'b1;
    send(1'b0);
    send(1'b0);
    wr_srst = 1'b0;
    last_mk = 1'b0;
  endtask

  task automatic lock_latency(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      good();
      if (bus.wa_lock) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic lock_up();
    for (int i = 0; i < 20 && m_mode != 4; i++) good();
    check("lock_up", {31'd0, bus.wa_lock}, 32'd1);
  endtask

  int lat;

  initial begin
    wr_srst = 1'b1;
    bus.r_wa_en = 1'b1;
    bus.r_err_clr = 1'b0;
    bus.mark_bit_location = 1'b0;
    bus.aib_hssi_tx_data_in = '0;
    model_reset();
    last_mk = 1'b0;

    // Reset state
    do_reset();
    check("rst_lock", {31'd0, bus.wa_lock}, 32'd0);
    check("rst_testbus", {12'd0, bus.wa_ctrl_testbus}, 32'd0);

    // Bypass
    bus.r_wa_en = 1'b0;
    do_reset();
    send(1'b0);
    check("byp_lock", {31'd0, bus.wa_lock}, 32'd1);
    check("byp_fifo", {31'd0, bus.fifo_wr_en}, 32'd1);
    repeat (3) send(1'b0);
    check("byp_state", {29'd0, bus.wa_ctrl_testbus[12:10]}, 32'd1);
    bus.r_wa_en = 1'b1;

    // Lock latency on bit 39, then bit 19
    do_reset();
    lock_latency(lat);
    check("lock_lat_b39", lat, LOCK_CNT + 1);
    bus.mark_bit_location = 1'b1;
    do_reset();
    lock_latency(lat);
    check("lock_lat_b19", lat, LOCK_CNT + 1);
    bus.mark_bit_location = 1'b0;

    // Broken verify: 1,0,1,1,0,1,0,1,0
    do_reset();
    send(1); send(0); send(1); send(1); send(0); send(1); send(0); send(1);
    check("brk_not_yet", {31'd0, bus.wa_lock}, 32'd0);
    send(0);
    check("brk_locked", {31'd0, bus.wa_lock}, 32'd1);

    // Two errors while locked
    do_reset();
    lock_up();
    miss(); miss(); good(); good(); good();
    check("err2_cnt", {24'd0, bus.err_cnt}, 32'd2);
    check("err2_lock", {31'd0, bus.wa_lock}, 32'd1);
    check("err2_sticky", {31'd0, bus.wa_err_sticky}, 32'd0);

    // Loss of alignment
    do_reset();
    lock_up();
    pulses_seen = 0;
    miss(); miss(); miss(); good();
`ifdef C3AIBADAPT_WA_RELOCK_EN
    check("loss_pulses", pulses_seen, 32'd1);
    check("loss_unlock", {31'd0, bus.wa_lock}, 32'd0);
    good(); good(); good();
    check("relock_not_yet", {31'd0, bus.wa_lock}, 32'd0);
    good();
    check("relock", {31'd0, bus.wa_lock}, 32'd1);
`else
    check("loss_pulses", pulses_seen, 32'd0);
    check("loss_keep_lock", {31'd0, bus.wa_lock}, 32'd1);
    check("loss_sticky", {31'd0, bus.wa_err_sticky}, 32'd1);
`endif

    // Reset while locked
    do_reset();
    lock_up();
    wr_srst = 1'b1;
    good();
    check("midrst_lock", {31'd0, bus.wa_lock}, 32'd0);
    check("midrst_fifo", {31'd0, bus.fifo_wr_en}, 32'd0);
    check("midrst_testbus", {12'd0, bus.wa_ctrl_testbus}, 32'd0);
    wr_srst = 1'b0;
    last_mk = 1'b0;

`ifndef C3AIBADAPT_WA_RELOCK_EN
    // Saturation and clear (clear wins over a same-cycle miss)
    lock_up();
    repeat (301) miss();
    check("sat_cnt", {24'd0, bus.err_cnt}, 32'd255);
    check("sat_sticky", {31'd0, bus.wa_err_sticky}, 32'd1);
    bus.r_err_clr = 1'b1;
    miss();
    bus.r_err_clr = 1'b0;
    check("clr_cnt", {24'd0, bus.err_cnt}, 32'd0);
    check("clr_sticky", {31'd0, bus.wa_err_sticky}, 32'd0);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wr_srst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) bus.r_wa_en = ~bus.r_wa_en;
      else if (!bus.r_wa_en && $urandom_range(0, 5) == 0) bus.r_wa_en = 1'b1;
      bus.r_err_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) bus.mark_bit_location = ~bus.mark_bit_location;
      if ($urandom_range(0, 4) == 0) miss();
      else good();
    end
    wr_srst = 1'b0;
    bus.r_err_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
